mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 28 ++
 rtl/mult_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

  localparam int unsigned DEFAULT_INPUT_SIZE = 1024;

  // The multiplier wait budget scales with operand width.
  function automatic int unsigned default_timeout(input int unsigned width);
    return 2 * width;
  endfunction

  localparam int unsigned DEFAULT_TIMEOUT = 2 * DEFAULT_INPUT_SIZE;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: search begins one past the last served index.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_idx_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  int unsigned cand;

  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    cand     = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = 32'(last_idx_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_o && req_i[IDX_W'(cand)]) begin
        any_o    = 1'b1;
        winner_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared multiplier with a wait timeout.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = DEFAULT_INPUT_SIZE,
  parameter int unsigned OUTPUT_SIZE = 2 * INPUT_SIZE,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT     = default_timeout(INPUT_SIZE)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*INPUT_SIZE-1:0] op_a_in,
  input  logic [NUM_REQ*INPUT_SIZE-1:0] op_b_in,
  output logic [NUM_REQ-1:0]            grant_out,
  output logic [OUTPUT_SIZE-1:0]        result_out,
  output logic [NUM_REQ-1:0]            result_valid_out,
  output logic                          err_out,
  output logic                          busy_out,
  output logic [INPUT_SIZE-1:0]         mul_a_out,
  output logic [INPUT_SIZE-1:0]         mul_b_out,
  output logic                          mul_ready_out,
  input  logic                          mul_busy_in,
  input  logic                          mul_valid_in,
  input  logic [OUTPUT_SIZE-1:0]        mul_result_in
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]       win_q, win_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [NUM_REQ-1:0]     rv_q, rv_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic [OUTPUT_SIZE-1:0] result_q, result_d;
  logic [INPUT_SIZE-1:0]  mul_a_q, mul_a_d;
  logic [INPUT_SIZE-1:0]  mul_b_q, mul_b_d;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   issue_go;
  logic                   timeout_hit;

  logic [INPUT_SIZE-1:0]  op_a_arr [NUM_REQ];
  logic [INPUT_SIZE-1:0]  op_b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign op_a_arr[g] = op_a_in[g*INPUT_SIZE +: INPUT_SIZE];
    assign op_b_arr[g] = op_b_in[g*INPUT_SIZE +: INPUT_SIZE];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i      (req_in),
    .last_idx_i (last_q),
    .winner_o   (pick_idx),
    .any_o      (pick_any)
  );

  // A busy multiplier defers a new issue even when a request is pending.
  assign issue_go    = pick_any && !mul_busy_in;
  assign timeout_hit = (cnt_q == CNT_LAST);

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (issue_go) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (mul_valid_in || timeout_hit) state_d = ST_RESPOND;
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    win_d    = win_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    grant_d  = '0;
    rv_d     = '0;
    ready_d  = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    busy_d   = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (issue_go) begin
          win_d   = pick_idx;
          mul_a_d = op_a_arr[pick_idx];
          mul_b_d = op_b_arr[pick_idx];
          grant_d = idx_onehot(pick_idx);
          ready_d = 1'b1;
        end
      end
      ST_ISSUE: cnt_d = '0;
      ST_WAIT: begin
        // Valid wins over a coincident timeout.
        if (mul_valid_in) begin
          result_d = mul_result_in;
          err_d    = 1'b0;
          rv_d     = idx_onehot(win_q);
        end else if (timeout_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          rv_d     = idx_onehot(win_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESPOND: last_d = win_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      win_q    <= '0;
      last_q   <= LAST_RST;
      cnt_q    <= '0;
      grant_q  <= '0;
      rv_q     <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      win_q    <= win_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
    end
  end

  assign grant_out        = grant_q;
  assign result_valid_out = rv_q;
  assign err_out          = err_q;
  assign busy_out         = busy_q;
  assign mul_ready_out    = ready_q;
  assign result_out       = result_q;
  assign mul_a_out        = mul_a_q;
  assign mul_b_out        = mul_b_q;

endmodule
